vlsu_req_queue: RTL

VLSU_REQ_QUEUE -- requirements
Module: vlsu_req_queue

---
 rtl/vlsu_req_queue.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/vlsu_req_queue.sv
// Purpose : request queue in front of the VLSU; in-flight requests all share one direction.
// Latency : 1 cycle push -> vlsu_req_valid_o (0 cycles with VLSU_REQ_QUEUE_BYPASS_EN defined).
// Backpr. : req_ready_o drops when the FIFO is full; issue stalls at MaxInflight or on a direction change.
//
// Optional feature macro: VLSU_REQ_QUEUE_BYPASS_EN (same-cycle pass-through when the queue is empty).
//
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   req_valid_i / req_ready_o / req_i    upstream dispatcher handshake
//   vlsu_req_valid_o / vlsu_req_ready_i  downstream VLSU request handshake
//   vlsu_req_o                           request presented to the VLSU
//   done_i                               one-cycle pulse: one issued request retired
//   count_o, inflight_o                  FIFO occupancy and issued-but-not-retired count
//   idle_o, err_o                        nothing queued or in flight; sticky done-underflow flag
//
// The isLoad field must be the least-significant bit of the packed payload
// (with the default vlsu_req_t = logic the payload is isLoad itself).

module vlsu_req_queue #(
  parameter int unsigned Depth       = 4,
  parameter int unsigned MaxInflight = 2,
  parameter type         vlsu_req_t  = logic
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  vlsu_req_t                        req_i,
  output logic                             vlsu_req_valid_o,
  input  logic                             vlsu_req_ready_i,
  output vlsu_req_t                        vlsu_req_o,
  input  logic                             done_i,
  output logic [$clog2(Depth+1)-1:0]       count_o,
  output logic [$clog2(MaxInflight+1)-1:0] inflight_o,
  output logic                             idle_o,
  output logic                             err_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned InfW = $clog2(MaxInflight + 1);

  // Storage and state
  vlsu_req_t         mem_q [Depth];
  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [InfW-1:0]   inflight_q;
  logic              dir_q;       // direction of the requests currently in flight (1 = load)
  logic              err_q;

  // Combinational control
  vlsu_req_t         head;
  vlsu_req_t         cand;        // request that would issue this cycle
  logic              cand_is_load;
  logic              issue_ok;
  logic              fifo_valid;
  logic              bypass;
  logic              issue;
  logic              push;
  logic              pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign head = mem_q[rd_ptr_q];

`ifdef VLSU_REQ_QUEUE_BYPASS_EN
  // With an empty FIFO the incoming request is the issue candidate.
  assign cand   = (count_q == '0) ? req_i : head;
  assign bypass = (count_q == '0) && issue_ok && req_valid_i;
  assign vlsu_req_o = bypass ? req_i : head;
`else
  // No path from req_i / req_valid_i to the VLSU side: everything goes through the FIFO.
  assign cand   = head;
  assign bypass = 1'b0;
  assign vlsu_req_o = head;
`endif

  assign cand_is_load = 1'(cand);

  // A new request may join the in-flight set only if it travels in the same
  // direction, so loads and stores never overtake one another.
  assign issue_ok = (inflight_q < InfW'(MaxInflight)) &&
                    ((inflight_q == '0) || (cand_is_load == dir_q));

  assign fifo_valid       = (count_q != '0) && issue_ok;
  assign vlsu_req_valid_o = !rst_i && (fifo_valid || bypass);
  assign req_ready_o      = !rst_i && (count_q < CntW'(Depth));

  assign issue = vlsu_req_valid_o && vlsu_req_ready_i;
  // A bypassed request that is accepted downstream never occupies a FIFO slot.
  assign push  = req_valid_i && req_ready_o && !(bypass && vlsu_req_ready_i);
  assign pop   = issue && !bypass;

  // Payload storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= req_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      dir_q      <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase

      if (issue) begin
        dir_q <= cand_is_load;
      end

      // issue is only possible below MaxInflight, so the increment cannot overflow.
      if (issue && !done_i) begin
        inflight_q <= inflight_q + InfW'(1);
      end else if (!issue && done_i) begin
        if (inflight_q == '0) begin
          err_q <= 1'b1;
        end else begin
          inflight_q <= inflight_q - InfW'(1);
        end
      end
    end
  end

  assign count_o    = count_q;
  assign inflight_o = inflight_q;
  assign idle_o     = (count_q == '0) && (inflight_q == '0);
  assign err_o      = err_q;

endmodule
